uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1_if.sv | 17 +
 rtl/uart_rx_8n1.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Serial-line side of the 8N1 receiver: raw RX in, byte/ready handshake out.
// frm_err is only present when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_8n1_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frm_err;

    modport master (output RX, clr_rdy, input rx_data, rdy, frm_err);
    modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err);
`else
    modport master (output RX, clr_rdy, input rx_data, rdy);
    modport slave  (input RX, clr_rdy, output rx_data, rdy);
`endif
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from a 12-bit baud down-counter.
// Define UART_RX_FRAME_ERR_EN to check the stop bit and drive frm_err.
module uart_rx_8n1 #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input logic          clk,
    input logic          rst,
    uart_rx_8n1_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a falling edge on rx_s
    // START | timing to mid start bit, rejects glitches
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | timing to mid stop bit, then frame done

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL_BIT = 12'(BAUD_DIV);

    state_t      state, state_nxt;
    logic        rx_meta, rx_s, rx_prev;
    logic        fall;
    logic [11:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        tc;
    logic        start_det;
    logic        stop_tc;
    logic        frame_ok, frame_ok_q;
    logic [7:0]  rx_data_q;
    logic        rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

    // Terminal count fires as the counter steps to zero, so samples land exactly BAUD_DIV apart.
    assign tc = (baud_cnt == 12'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= 12'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        start_det    = 1'b0;
        stop_tc      = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    baud_cnt_nxt = HALF_BIT;
                    start_det    = 1'b1;
                    state_nxt    = START;
                end
            end
            START: begin
                if (!tc) begin
                    baud_cnt_nxt = baud_cnt - 12'd1;
                end else if (rx_s) begin
                    baud_cnt_nxt = 12'd0;
                    state_nxt    = IDLE;
                end else begin
                    baud_cnt_nxt = FULL_BIT;
                    bit_cnt_nxt  = 3'd0;
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                if (!tc) begin
                    baud_cnt_nxt = baud_cnt - 12'd1;
                end else begin
                    shreg_nxt    = {rx_s, shreg[7:1]};
                    baud_cnt_nxt = FULL_BIT;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tc) begin
                    baud_cnt_nxt = baud_cnt - 12'd1;
                end else begin
                    stop_tc      = 1'b1;
                    baud_cnt_nxt = 12'd0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic frame_bad, frame_bad_q, frm_err_q;

    assign frame_ok  = stop_tc & rx_s;
    assign frame_bad = stop_tc & ~rx_s;

    // A bad frame outranks a same-cycle clear; a good frame always clears the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bad_q <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            frame_bad_q <= frame_bad;
            if (frame_bad_q) begin
                frm_err_q <= 1'b1;
            end else if (frame_ok_q || bus.clr_rdy) begin
                frm_err_q <= 1'b0;
            end
        end
    end

    assign bus.frm_err = frm_err_q;
`else
    assign frame_ok = stop_tc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_ok_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
        end else begin
            frame_ok_q <= frame_ok;
            if (frame_ok) begin
                rx_data_q <= shreg;
            end
            if (frame_ok_q) begin
                rdy_q <= 1'b1;
            end else if (start_det || bus.clr_rdy) begin
                rdy_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: timing-based frame model compared every cycle, plus literal checks.
// Honours UART_RX_FRAME_ERR_EN for the stop-bit scenario.
module tb_uart_rx_8n1;
    localparam int BD = 434;
    localparam int H  = BD / 2;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_8n1_if bus ();

    uart_rx_8n1 #(.BAUD_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         start;
        logic [7:0] d;
        bit         stop;
        bit         false_start;
    } frame_t;

    frame_t     frames[$];
    int         cyc     = 0;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] data_m  = 8'h00;
    logic       rdy_m   = 1'b0;
    logic       ferr_m  = 1'b0;
    bit         done_p  = 1'b0;
    bit         ok_p    = 1'b0;
    bit         start_ev, done_now, ok_now;
    logic       nr, nf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: each sent frame is a start edge number; the DUT sees RX three edges later,
    // latches the byte at the mid-stop-bit edge and raises rdy on the edge after.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            data_m = 8'h00; rdy_m = 1'b0; ferr_m = 1'b0;
            done_p = 1'b0;  ok_p = 1'b0;
            frames.delete();
        end else begin
            start_ev = 1'b0; done_now = 1'b0; ok_now = 1'b0;
            foreach (frames[i]) begin
                if (cyc == frames[i].start + 3) start_ev = 1'b1;
                if (!frames[i].false_start && cyc == frames[i].start + 3 + H + 9 * BD) begin
                    done_now = 1'b1;
                    ok_now   = frames[i].stop || !FEAT;
                    if (ok_now) data_m = frames[i].d;
                end
            end
            nr = rdy_m;
            nf = ferr_m;
            if (start_ev || bus.clr_rdy) nr = 1'b0;
            if (bus.clr_rdy) nf = 1'b0;
            if (done_p) begin
                if (ok_p) begin nr = 1'b1; nf = 1'b0; end
                else nf = 1'b1;
            end
            rdy_m  = nr;
            ferr_m = nf;
            done_p = done_now;
            ok_p   = ok_now;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_rx_data", bus.rx_data, data_m);
            check("cyc_rdy", bus.rdy, rdy_m);
`ifdef UART_RX_FRAME_ERR_EN
            check("cyc_frm_err", bus.frm_err, ferr_m);
`endif
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rdy(input int budget, input string name);
        int i = 0;
        while (!bus.rdy && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check(name, bus.rdy, 1);
    endtask

    task automatic pulse_clr();
        bus.clr_rdy = 1'b1;
        wait_cycles(1);
        bus.clr_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop);
        frames.push_back('{start: cyc, d: d, stop: stop, false_start: 1'b0});
        bus.RX = 1'b0;
        wait_cycles(BD);
        for (int k = 0; k < 8; k++) begin
            bus.RX = d[k];
            wait_cycles(BD);
        end
        bus.RX = stop;
        wait_cycles(BD);
    endtask

    int n;
    logic [7:0] rst_byte;

    initial begin
        bus.RX      = 1'b1;
        bus.clr_rdy = 1'b0;
        wait_cycles(3);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rdy", bus.rdy, 0);
`ifdef UART_RX_FRAME_ERR_EN
        check("reset_frm_err", bus.frm_err, 0);
`endif
        rst = 1'b0;
        wait_cycles(20);

        // 3 + 217 + 9*434 = 4126: byte lands on that edge, rdy on the next
        n = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_until(n + 4125);
                check("a5_data_early", bus.rx_data, 8'h00);
                wait_until(n + 4126);
                check("a5_data", bus.rx_data, 8'hA5);
                check("a5_rdy_early", bus.rdy, 0);
                wait_until(n + 4127);
                check("a5_rdy", bus.rdy, 1);
            end
        join
        pulse_clr();
        check("a5_clr", bus.rdy, 0);

        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_rdy(12 * BD, "b2b_rdy_first");
                check("b2b_data_first", bus.rx_data, 8'h00);
                pulse_clr();
                check("b2b_clr_first", bus.rdy, 0);
                wait_rdy(12 * BD, "b2b_rdy_second");
                check("b2b_data_second", bus.rx_data, 8'hFF);
                pulse_clr();
                check("b2b_clr_second", bus.rdy, 0);
            end
        join
        wait_cycles(BD);

        frames.push_back('{start: cyc, d: 8'h00, stop: 1'b1, false_start: 1'b1});
        bus.RX = 1'b0;
        wait_cycles(150);
        bus.RX = 1'b1;
        wait_cycles(2 * BD);
        check("glitch_rdy", bus.rdy, 0);
        check("glitch_data", bus.rx_data, 8'hFF);

        send_frame(8'h5A, 1'b1);
        check("pre_collide_rdy", bus.rdy, 1);
        check("pre_collide_data", bus.rx_data, 8'h5A);
        n = cyc;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_until(n + 4126);
                bus.clr_rdy = 1'b1;
                wait_cycles(1);
                bus.clr_rdy = 1'b0;
                check("collide_rdy", bus.rdy, 1);
                check("collide_data", bus.rx_data, 8'hC3);
            end
        join
        pulse_clr();
        check("collide_clr", bus.rdy, 0);
        wait_cycles(BD);

        rst_byte = 8'hB6;
        frames.push_back('{start: cyc, d: rst_byte, stop: 1'b1, false_start: 1'b0});
        bus.RX = 1'b0;
        wait_cycles(BD);
        for (int k = 0; k < 5; k++) begin
            bus.RX = rst_byte[k];
            wait_cycles(k == 4 ? H : BD);
        end
        #2 rst = 1'b1;
        bus.RX = 1'b1;
        #1;
        check("midrst_data", bus.rx_data, 8'h00);
        check("midrst_rdy", bus.rdy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(BD);
        check("post_rst_idle_rdy", bus.rdy, 0);
        send_frame(8'h81, 1'b1);
        check("post_rst_rdy", bus.rdy, 1);
        check("post_rst_data", bus.rx_data, 8'h81);

`ifdef UART_RX_FRAME_ERR_EN
        send_frame(8'h3C, 1'b0);
        bus.RX = 1'b1;
        wait_cycles(BD);
        check("bad_stop_frm_err", bus.frm_err, 1);
        check("bad_stop_rdy", bus.rdy, 0);
        check("bad_stop_data", bus.rx_data, 8'h81);
        send_frame(8'h42, 1'b1);
        check("good_frm_err", bus.frm_err, 0);
        check("good_rdy", bus.rdy, 1);
        check("good_data", bus.rx_data, 8'h42);
`else
        send_frame(8'h3C, 1'b0);
        bus.RX = 1'b1;
        wait_cycles(BD);
        check("stop_ignored_rdy", bus.rdy, 1);
        check("stop_ignored_data", bus.rx_data, 8'h3C);
`endif

        wait_cycles(10);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
